jx2_ex_cs_add_pipe: RTL and testbench

- Parametrised, two-stage pipelined carry-select adder/subtractor for the EX address/integer path.
- Successor to the fixed 48-bit combinational carry-select adder. Width, segment size and effective address width are configurable.
- Adds subtract, carry-in, carry/overflow flags, runtime high-bit extension mode (full / zero-extend / sign-extend) and a valid/ready handshake with stall.
- Sits between operand fetch and EX writeback/AGU consumers.

---
 rtl/jx2_ex_cs_add_pipe.sv | 181 ++++++++++++++++++
 tb/tb_jx2_ex_cs_add_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jx2_ex_cs_add_pipe.sv
// ---------------------------------------------------------------------------
// jx2_ex_cs_add_pipe
// Two-stage pipelined carry-select adder/subtractor for the EX address and
// integer path. Stage 1 pre-computes, for every SEG-bit segment, the segment
// sum assuming carry-in 0 and carry-in 1. Stage 2 resolves the select chain,
// derives carry/overflow from the raw full-width sum and applies the
// high-bit extension mode. A valid/ready handshake with back-pressure holds
// up to two results when the consumer stalls.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   inValid   in   operands valid
//   inReady   out  operands accepted this cycle when inValid is also high
//                  (combinational from pipe occupancy and outReady)
//   valA/valB in   WIDTH-bit operands
//   carryIn   in   carry-in for add, ignored when sub=1
//   sub       in   1: A + ~B + 1
//   extMode   in   00 full, 01 zero-extend above ADDR_BITS,
//                  10 sign-extend from ADDR_BITS-1, 11 same as 00
//   outValid  out  result valid
//   outReady  in   consumer accepts result
//   valC      out  WIDTH-bit result (extension applied)
//   carryOut  out  carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   ovf       out  signed overflow at bit WIDTH-1
// ---------------------------------------------------------------------------
module jx2_ex_cs_add_pipe #(
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned SEG       = 16,
   parameter int unsigned ADDR_BITS = 48
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   input  logic             carryIn,
   input  logic             sub,
   input  logic [1:0]       extMode,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] valC,
   output logic             carryOut,
   output logic             ovf
);

   localparam int unsigned NSEG = WIDTH / SEG;
   localparam int unsigned SW   = SEG + 1;

   // Bits above the effective address width; all-zero when ADDR_BITS == WIDTH
   // because the shift then yields zero and the decrement wraps to all ones.
   localparam logic [WIDTH-1:0] HI_MASK =
      ~((WIDTH'(1) << ADDR_BITS) - WIDTH'(1));

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s1_valid_q, s1_valid_d;
   logic out_valid_q, out_valid_d;
   logic s2_adv;
   logic s1_load;
   logic s2_load;

   assign s2_adv   = !out_valid_q || outReady;
   assign inReady  = !s1_valid_q || s2_adv;
   assign s1_load  = inValid && inReady;
   assign s2_load  = s2_adv && s1_valid_q;

   // ------------------------------------------------------------------
   // Stage 1: per-segment speculative sums
   // ------------------------------------------------------------------
   logic [NSEG-1:0][SEG:0] s1_sum0_q, s1_sum0_d;
   logic [NSEG-1:0][SEG:0] s1_sum1_q, s1_sum1_d;
   logic                   s1_cin_q,  s1_cin_d;
   logic                   s1_amsb_q, s1_amsb_d;
   logic                   s1_bmsb_q, s1_bmsb_d;
   logic [1:0]             s1_ext_q,  s1_ext_d;

   // Segment 0 is treated like the others: both candidates are kept and the
   // registered effective carry-in picks between them in stage 2.
   always_comb begin
      logic [WIDTH-1:0] b_eff;
      logic [SEG:0]     a_seg;
      logic [SEG:0]     b_seg;
      b_eff     = sub ? ~valB : valB;
      a_seg     = '0;
      b_seg     = '0;
      s1_sum0_d = '0;
      s1_sum1_d = '0;
      for (int k = 0; k < int'(NSEG); k++) begin
         a_seg        = SW'(valA[k*SEG +: SEG]);
         b_seg        = SW'(b_eff[k*SEG +: SEG]);
         s1_sum0_d[k] = a_seg + b_seg;
         s1_sum1_d[k] = a_seg + b_seg + SW'(1);
      end
      s1_cin_d  = sub | carryIn;
      s1_amsb_d = valA[WIDTH-1];
      s1_bmsb_d = b_eff[WIDTH-1];
      s1_ext_d  = extMode;
   end

   // Stage 1 stays full while its result cannot move into the output stage.
   assign s1_valid_d = s1_load || (s1_valid_q && !s2_adv);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_sum0_q  <= '0;
         s1_sum1_q  <= '0;
         s1_cin_q   <= 1'b0;
         s1_amsb_q  <= 1'b0;
         s1_bmsb_q  <= 1'b0;
         s1_ext_q   <= 2'b00;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_load) begin
            s1_sum0_q <= s1_sum0_d;
            s1_sum1_q <= s1_sum1_d;
            s1_cin_q  <= s1_cin_d;
            s1_amsb_q <= s1_amsb_d;
            s1_bmsb_q <= s1_bmsb_d;
            s1_ext_q  <= s1_ext_d;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: select chain, flags, extension
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] val_c_q, val_c_d;
   logic             carry_q, carry_d;
   logic             ovf_q,   ovf_d;

   always_comb begin
      logic [WIDTH-1:0] raw;
      logic [SEG:0]     sel;
      logic             carry;
      raw   = '0;
      sel   = '0;
      carry = s1_cin_q;
      // Carry into each segment is the MSB of the previously selected sum.
      for (int k = 0; k < int'(NSEG); k++) begin
         sel                = carry ? s1_sum1_q[k] : s1_sum0_q[k];
         raw[k*SEG +: SEG]  = sel[SEG-1:0];
         carry              = sel[SEG];
      end
      carry_d = carry;
      // Flags always come from the raw full-width sum.
      ovf_d   = (s1_amsb_q == s1_bmsb_q) && (raw[WIDTH-1] != s1_amsb_q);
      unique case (s1_ext_q)
         2'b01:   val_c_d = raw & ~HI_MASK;
         2'b10:   val_c_d = raw[ADDR_BITS-1] ? (raw | HI_MASK) : (raw & ~HI_MASK);
         default: val_c_d = raw;
      endcase
   end

   assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         val_c_q     <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (s2_load) begin
            val_c_q <= val_c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
         end
      end
   end

   assign outValid = out_valid_q;
   assign valC     = val_c_q;
   assign carryOut = carry_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_jx2_ex_cs_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_jx2_ex_cs_add_pipe
// Directed and randomized bench for the pipelined carry-select adder.
// A queue-based reference model computes each accepted operation with plain
// (WIDTH+1)-bit arithmetic and is compared against every visible output.
// ---------------------------------------------------------------------------
module tb_jx2_ex_cs_add_pipe;

   localparam int unsigned W  = 64;
   localparam int unsigned SG = 16;
   localparam int unsigned AB = 48;

   logic         clock;
   logic         reset;
   logic         inValid;
   logic         inReady;
   logic [W-1:0] valA;
   logic [W-1:0] valB;
   logic         carryIn;
   logic         sub;
   logic [1:0]   extMode;
   logic         outValid;
   logic         outReady;
   logic [W-1:0] valC;
   logic         carryOut;
   logic         ovf;

   typedef struct {
      logic [W-1:0] c;
      logic         co;
      logic         ov;
   } exp_t;

   exp_t sbq[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   jx2_ex_cs_add_pipe #(.WIDTH(W), .SEG(SG), .ADDR_BITS(AB)) dut (
      .clock    (clock),
      .reset    (reset),
      .inValid  (inValid),
      .inReady  (inReady),
      .valA     (valA),
      .valB     (valB),
      .carryIn  (carryIn),
      .sub      (sub),
      .extMode  (extMode),
      .outValid (outValid),
      .outReady (outReady),
      .valC     (valC),
      .carryOut (carryOut),
      .ovf      (ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: straight modular arithmetic, then extension of the low AB bits.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb, input logic [1:0] em);
      exp_t         e;
      logic [W:0]   s;
      logic [W-1:0] be;
      be   = sb ? ~b : b;
      s    = {1'b0, a} + {1'b0, be} + (W+1)'(sb ? 1'b1 : ci);
      e.co = s[W];
      e.ov = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
      case (em)
         2'd1:    e.c = W'(s[AB-1:0]);
         2'd2:    e.c = W'($signed(s[AB-1:0]));
         default: e.c = s[W-1:0];
      endcase
      return e;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input logic [1:0] em, input logic iv, input logic ordy);
      valA     = a;
      valB     = b;
      carryIn  = ci;
      sub      = sb;
      extMode  = em;
      inValid  = iv;
      outReady = ordy;
      #1;
   endtask

   // One clock: scoreboard check of the visible result, model update, advance.
   task automatic tick();
      logic acc;
      acc = inValid && inReady;
      if (outValid) begin
         if (sbq.size() == 0) begin
            chk1("sb_unexpected_out", outValid, 1'b0);
         end else begin
            chk("sb_valc", valC, sbq[0].c);
            chk1("sb_carry", carryOut, sbq[0].co);
            chk1("sb_ovf", ovf, sbq[0].ov);
            if (outReady) void'(sbq.pop_front());
         end
      end
      if (acc) sbq.push_back(model(valA, valB, carryIn, sub, extMode));
      @(posedge clock);
      @(negedge clock);
   endtask

   // Single operation with explicit expected result and 2-cycle latency check.
   task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic sb, input logic [1:0] em,
                           input logic [W-1:0] ec, input logic eco, input logic eov);
      drive(a, b, ci, sb, em, 1'b1, 1'b1);
      chk1({tag, "_inready"}, inReady, 1'b1);
      tick();
      drive('0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      chk1({tag, "_early_valid"}, outValid, 1'b0);
      tick();
      chk1({tag, "_valid"}, outValid, 1'b1);
      chk({tag, "_valc"}, valC, ec);
      chk1({tag, "_carry"}, carryOut, eco);
      chk1({tag, "_ovf"}, ovf, eov);
      tick();
   endtask

   function automatic logic [W-1:0] rand_val();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '1;
         1:       v = '0;
         2:       v = 64'h0000_7FFF_FFFF_FFFF;
         3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
         4:       v = 64'h0000_0000_FFFF_FFFF;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      logic [W-1:0] fa[4];
      logic [W-1:0] fb[4];
      int           idx;
      int           budget;
      logic         acc;
      exp_t         e;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      logic [1:0]   rm;

      reset = 1'b0;
      drive('0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      @(negedge clock);
      @(negedge clock);
      chk1("reset_outvalid", outValid, 1'b0);
      chk("reset_valc", valC, '0);
      chk1("reset_carry", carryOut, 1'b0);
      chk1("reset_ovf", ovf, 1'b0);
      reset = 1'b1;
      #1;
      chk1("reset_inready", inReady, 1'b1);
      @(negedge clock);

      // Directed arithmetic and extension cases
      directed("zext_carry48", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 2'd1,
               64'h0, 1'b0, 1'b0);
      directed("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 2'd0,
               64'h0, 1'b1, 1'b0);
      directed("sext47", 64'h0000_7FFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 2'd2,
               64'hFFFF_8000_0000_0000, 1'b0, 1'b0);
      directed("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 2'd0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      directed("cin_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 2'd0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
      directed("sub_ignores_cin", 64'd9, 64'd9, 1'b0, 1'b1, 2'd3,
               64'h0, 1'b1, 1'b0);

      // Back-to-back 1+1, 2+2, 3+3 with no bubbles
      for (int i = 0; i < 6; i++) begin
         drive(W'(i + 1), W'(i + 1), 1'b0, 1'b0, 2'd0, (i < 3), 1'b1);
         chk1("b2b_valid", outValid, (i >= 2 && i <= 4));
         if (i >= 2 && i <= 4) chk("b2b_valc", valC, W'(2 * (i - 1)));
         tick();
      end

      // Fill with outReady low, then drain
      for (int i = 0; i < 4; i++) begin
         fa[i] = rand_val();
         fb[i] = rand_val();
      end
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         drive(fa[idx], fb[idx], 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
         acc = inValid && inReady;
         tick();
         if (acc) idx++;
      end
      drive(fa[idx], fb[idx], 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      chk("fill_accepted", W'(idx), W'(2));
      chk1("fill_inready", inReady, 1'b0);
      chk1("fill_outvalid", outValid, 1'b1);
      e = model(fa[0], fb[0], 1'b0, 1'b0, 2'd0);
      chk("fill_held_valc", valC, e.c);
      budget = 0;
      while ((idx < 4 || sbq.size() > 0) && budget < 20) begin
         drive((idx < 4) ? fa[idx % 4] : '0, (idx < 4) ? fb[idx % 4] : '0,
               1'b0, 1'b0, 2'd0, (idx < 4), 1'b1);
         acc = inValid && inReady;
         tick();
         if (acc) idx++;
         budget++;
      end
      chk1("drain_done", (idx == 4) && (sbq.size() == 0), 1'b1);

      // Randomized traffic with random stalls
      for (int c = 0; c < 400; c++) begin
         ra = rand_val();
         rb = rand_val();
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         rm = 2'($urandom_range(0, 3));
         drive(ra, rb, rc, rs, rm, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
         tick();
      end
      budget = 0;
      while (sbq.size() > 0 && budget < 10) begin
         drive('0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
         tick();
         budget++;
      end
      chk1("random_drain_done", (sbq.size() == 0), 1'b1);

      // Reset with two results in flight
      drive(64'd10, 64'd20, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      tick();
      drive(64'd30, 64'd40, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      tick();
      drive('0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      chk1("pre_reset_outvalid", outValid, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk1("async_reset_outvalid", outValid, 1'b0);
      sbq.delete();
      @(negedge clock);
      reset = 1'b1;
      drive('0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         chk1("post_reset_no_stale", outValid, 1'b0);
         tick();
      end
      ra = rand_val();
      rb = rand_val();
      e  = model(ra, rb, 1'b1, 1'b0, 2'd2);
      directed("post_reset_first", ra, rb, 1'b1, 1'b0, 2'd2, e.c, e.co, e.ov);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
